mem_access: RTL

MEM-stage unit of the RISC-V pipeline. It sits after the ex_mem register, consumes the execute stage's memory request and result, and performs LOAD/STORE over a byte-wide, single-port RAM one byte per cycle. It stalls the pipeline while an access is in flight, then hands the write-back result to mem_wb and to the register-file forwarding path. Non-memory instructions pass through combinationally.

---
 rtl/mem_access.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// MEM-stage load/store unit. Moves one byte per cycle over a byte-wide single-port RAM,
// stalls the pipeline while an access is in flight and hands the result to mem_wb and
// the forwarding path. Non-memory instructions pass through combinationally.
module mem_access #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            aluop_i,
  input  logic [2:0]            alufunct3_i,
  input  logic                  me_i,
  input  logic [ADDR_W-1:0]     maddr_i,
  input  logic                  wreg_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [7:0]            mem_din_i,
  output logic [ADDR_W-1:0]     mem_a_o,
  output logic [7:0]            mem_dout_o,
  output logic                  mem_wr_o,
  output logic                  stall_req_o,
  output logic                  wreg_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  wreg_f,
  output logic [REG_ADDR_W-1:0] wd_f,
  output logic [DATA_W-1:0]     wdata_f
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  typedef enum logic [1:0] {StIdle, StLoad, StStore, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] ld_buf_q, ld_buf_d;

  logic        is_load, is_store, ld_ok, st_ok, access, mem_op;
  logic [2:0]  n_bytes;
  logic [2:0]  k_m1;
  logic [31:0] ld_ext;

  // Decode opcode/funct3 into access kind and byte count.
  always_comb begin
    is_load  = (aluop_i == OpLoad);
    is_store = (aluop_i == OpStore);
    ld_ok    = (alufunct3_i == 3'b000) || (alufunct3_i == 3'b001) || (alufunct3_i == 3'b010) ||
               (alufunct3_i == 3'b100) || (alufunct3_i == 3'b101);
    st_ok    = (alufunct3_i == 3'b000) || (alufunct3_i == 3'b001) || (alufunct3_i == 3'b010);
    mem_op   = me_i && (is_load || is_store);
    access   = me_i && ((is_load && ld_ok) || (is_store && st_ok));
    case (alufunct3_i[1:0])
      2'b00:   n_bytes = 3'd1;
      2'b01:   n_bytes = 3'd2;
      default: n_bytes = 3'd4;
    endcase
    k_m1 = k_q - 3'd1;
  end

  // Extend the assembled load buffer according to the load flavour.
  always_comb begin
    case (alufunct3_i)
      3'b000:  ld_ext = {{24{ld_buf_q[7]}}, ld_buf_q[7:0]};
      3'b001:  ld_ext = {{16{ld_buf_q[15]}}, ld_buf_q[15:0]};
      3'b100:  ld_ext = {24'd0, ld_buf_q[7:0]};
      3'b101:  ld_ext = {16'd0, ld_buf_q[15:0]};
      default: ld_ext = ld_buf_q;
    endcase
  end

  // Next-state, byte sequencing and all outputs.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    ld_buf_d    = ld_buf_q;
    mem_a_o     = '0;
    mem_dout_o  = '0;
    mem_wr_o    = 1'b0;
    stall_req_o = 1'b0;
    wreg_o      = 1'b0;
    wd_o        = '0;
    wdata_o     = '0;

    case (state_q)
      StIdle: begin
        if (access) begin
          mem_a_o     = maddr_i;
          stall_req_o = 1'b1;
          k_d         = 3'd1;
          if (is_store) begin
            mem_dout_o = wdata_i[7:0];
            mem_wr_o   = 1'b1;
            state_d    = (n_bytes == 3'd1) ? StDone : StStore;
          end else begin
            state_d = StLoad;
          end
        end else if (!mem_op) begin
          wreg_o  = wreg_i;
          wd_o    = wd_i;
          wdata_o = wdata_i;
        end
        // Memory opcode with a bad funct3 is squashed: everything stays zero.
      end
      StStore: begin
        mem_a_o     = maddr_i + ADDR_W'(k_q);
        mem_dout_o  = wdata_i[{k_q[1:0], 3'b000} +: 8];
        mem_wr_o    = 1'b1;
        stall_req_o = 1'b1;
        if (k_q == n_bytes - 3'd1) begin
          state_d = StDone;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      StLoad: begin
        // RAM data lags the address by one cycle, so byte k-1 arrives in cycle k.
        ld_buf_d[{k_m1[1:0], 3'b000} +: 8] = mem_din_i;
        stall_req_o = 1'b1;
        if (k_q < n_bytes) begin
          mem_a_o = maddr_i + ADDR_W'(k_q);
        end else begin
          mem_a_o = maddr_i + ADDR_W'(k_m1);
        end
        if (k_q == n_bytes) begin
          state_d = StDone;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      StDone: begin
        wd_o = wd_i;
        if (is_load) begin
          wreg_o  = wreg_i;
          wdata_o = DATA_W'(ld_ext);
        end
        k_d     = 3'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (rst) begin
      mem_a_o     = '0;
      mem_dout_o  = '0;
      mem_wr_o    = 1'b0;
      stall_req_o = 1'b0;
      wreg_o      = 1'b0;
      wd_o        = '0;
      wdata_o     = '0;
    end
  end

  // Forwarding only sees a result once the stage is no longer stalling.
  always_comb begin
    wreg_f  = wreg_o & ~stall_req_o;
    wd_f    = wd_o;
    wdata_f = wdata_o;
  end

  // State, byte counter and load buffer with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      k_q      <= 3'd0;
      ld_buf_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      ld_buf_q <= ld_buf_d;
    end
  end

endmodule
